// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, bundle layout and state types for the memory stage
package core_pkg;

    localparam logic [5:0]  OP_LOAD       = 6'b010000;
    localparam logic [5:0]  OP_STORE      = 6'b010001;
    localparam logic [31:0] BUBBLE_SLOT   = {3'b111, 29'b0};
    localparam logic [63:0] BUBBLE_BUNDLE = {BUBBLE_SLOT, BUBBLE_SLOT};

    typedef enum logic [1:0] {
        EX_ALU,
        EX_LOAD,
        EX_STORE
    } exec_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [31:0] u_tdata;
        logic [31:0] l_tdata;
        logic [4:0]  u_rt;
        logic [4:0]  l_rt;
        logic        u_rt_flag;
        logic        l_rt_flag;
    } bundle_t;

    localparam bundle_t EMPTY_BUNDLE = '{
        pc:        32'h0,
        inst:      BUBBLE_BUNDLE,
        u_tdata:   32'h0,
        l_tdata:   32'h0,
        u_rt:      5'h0,
        l_rt:      5'h0,
        u_rt_flag: 1'b0,
        l_rt_flag: 1'b0
    };

    // Only the upper slot may carry a memory op; exec flags loads, stores are decoded here.
    function automatic exec_type decode_exec(input logic is_load, input logic [5:0] upper_op);
        exec_type t;
        t = EX_ALU;
        if (is_load) begin
            t = EX_LOAD;
        end else if (upper_op == OP_STORE) begin
            t = EX_STORE;
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: one outstanding data access per bundle, pass-through otherwise
module mem_access
    import core_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_to_mem_ready,
    input  logic [31:0]       pc,
    input  logic [63:0]       inst,
    input  logic [31:0]       u_tdata,
    input  logic [31:0]       l_tdata,
    input  logic [31:0]       u_sdata,
    input  logic [4:0]        u_rt,
    input  logic [4:0]        l_rt,
    input  logic              u_rt_flag,
    input  logic              l_rt_flag,
    output logic              mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic [31:0]       pc_to_the_next,
    output logic [63:0]       inst_to_the_next,
    output logic [31:0]       u_tdata_to_the_next,
    output logic [31:0]       l_tdata_to_the_next,
    output logic [4:0]        u_rt_to_the_next,
    output logic [4:0]        l_rt_to_the_next,
    output logic              u_rt_flag_to_the_next,
    output logic              l_rt_flag_to_the_next
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    bundle_t           r_out;
    bundle_t           r_hold;
    bundle_t           w_in;
    bundle_t           w_done;
    exec_type          w_exec_type;
    logic              w_mem_op;
    logic              w_timeout;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_mem_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [CNT_W-1:0]  r_cnt;

    assign w_in = '{
        pc:        pc,
        inst:      inst,
        u_tdata:   u_tdata,
        l_tdata:   l_tdata,
        u_rt:      u_rt,
        l_rt:      l_rt,
        u_rt_flag: u_rt_flag,
        l_rt_flag: l_rt_flag
    };

    assign w_exec_type = decode_exec(ex_to_mem_ready, inst[63:58]);
    assign w_mem_op    = (w_exec_type != EX_ALU);
    assign w_timeout   = (r_cnt == CNT_LAST);

    // A completed load replaces the upper result; a store writes no register.
    always_comb begin
        w_done = r_hold;
        if (r_mem_we) begin
            w_done.u_rt_flag = 1'b0;
        end else begin
            w_done.u_tdata = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_mem_op) w_next_state = BUSY;
            BUSY: begin
                if (mem_rvalid) begin
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_next_state = ERR;
                end
            end
            ERR:     w_next_state = ERR;
            default: w_next_state = IDLE;
        endcase
    end

    // The interlock must assert in the same cycle a memory op is presented.
    always_comb begin
        mem_stall = 1'b0;
        case (r_state)
            IDLE:    mem_stall = w_mem_op;
            BUSY:    mem_stall = ~mem_rvalid;
            ERR:     mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out       <= EMPTY_BUNDLE;
            r_hold      <= EMPTY_BUNDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_hold      <= w_in;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_exec_type == EX_STORE);
                        r_mem_addr  <= u_tdata[ADDR_W-1:0];
                        r_mem_wdata <= u_sdata;
                        r_cnt       <= '0;
                        r_out       <= EMPTY_BUNDLE;
                    end else begin
                        r_out <= w_in;
                    end
                end
                BUSY: begin
                    if (mem_rvalid) begin
                        r_out     <= w_done;
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_out <= EMPTY_BUNDLE;
                        if (w_timeout) begin
                            r_mem_err <= 1'b1;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_out <= EMPTY_BUNDLE;
                end
            endcase
        end
    end

    assign mem_req               = r_mem_req;
    assign mem_we                = r_mem_we;
    assign mem_addr              = r_mem_addr;
    assign mem_wdata             = r_mem_wdata;
    assign mem_err               = r_mem_err;
    assign pc_to_the_next        = r_out.pc;
    assign inst_to_the_next      = r_out.inst;
    assign u_tdata_to_the_next   = r_out.u_tdata;
    assign l_tdata_to_the_next   = r_out.l_tdata;
    assign u_rt_to_the_next      = r_out.u_rt;
    assign l_rt_to_the_next      = r_out.l_rt;
    assign u_rt_flag_to_the_next = r_out.u_rt_flag;
    assign l_rt_flag_to_the_next = r_out.l_rt_flag;

endmodule
